// File: rtl/cell_unit.sv
// cell_unit
// Cell-level client of memory_unit. Converts two-word cell operations into
// memory_unit command sequences:
//   CONS      : allocate two consecutive words, write head then tail,
//               return the base address.
//   READ_CELL : read head from base and tail from base+1.
//
// Ports
//   clk, rst (async, active-low), power (global enable; low freezes everything)
//   req_valid/req_ready/req_op/req_addr/req_head/req_tail : request handshake
//   rsp_valid/rsp_error/rsp_addr/rsp_head/rsp_tail        : one-cycle response
//   mem_func/mem_execute/mem_address/mem_write_data       : memory_unit command
//   mem_ready/mem_free_addr/mem_read_data                 : memory_unit results
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a request (req_ready when memory_unit is ready)
// ALLOC_REQ  | GET_FREE of two words issued this cycle
// ALLOC_WAIT | waiting for the allocation result
// WRH_REQ    | SET_CONTENTS of head at base issued
// WRH_WAIT   | waiting for head write to complete
// WRT_REQ    | SET_CONTENTS of tail at base+1 issued
// WRT_WAIT   | waiting for tail write to complete
// RDH_REQ    | GET_CONTENTS at base issued
// RDH_WAIT   | waiting for head word
// RDT_REQ    | GET_CONTENTS at base+1 issued
// RDT_WAIT   | waiting for tail word
// DONE       | response strobe, back to IDLE

module cell_unit #(
    parameter int unsigned memory_addr_width = 10,
    parameter int unsigned memory_data_width = 64,
    parameter logic [7:0]  TIMEOUT           = 8'd255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         power,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_op,
    input  logic [memory_addr_width-1:0] req_addr,
    input  logic [memory_data_width-1:0] req_head,
    input  logic [memory_data_width-1:0] req_tail,
    output logic                         rsp_valid,
    output logic                         rsp_error,
    output logic [memory_addr_width-1:0] rsp_addr,
    output logic [memory_data_width-1:0] rsp_head,
    output logic [memory_data_width-1:0] rsp_tail,
    output logic [1:0]                   mem_func,
    output logic                         mem_execute,
    output logic [memory_addr_width-1:0] mem_address,
    output logic [memory_data_width-1:0] mem_write_data,
    input  logic                         mem_ready,
    input  logic [memory_addr_width-1:0] mem_free_addr,
    input  logic [memory_data_width-1:0] mem_read_data
);

    localparam logic [1:0] GET_CONTENTS = 2'd0;
    localparam logic [1:0] SET_CONTENTS = 2'd1;
    localparam logic [1:0] GET_FREE     = 2'd2;

    localparam logic [1:0] OP_CONS = 2'd1;
    localparam logic [1:0] OP_READ = 2'd2;

    localparam logic [memory_addr_width-1:0] ADDR_ONES = '1;

    typedef enum logic [3:0] {
        IDLE, ALLOC_REQ, ALLOC_WAIT, WRH_REQ, WRH_WAIT, WRT_REQ, WRT_WAIT,
        RDH_REQ, RDH_WAIT, RDT_REQ, RDT_WAIT, DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [7:0]                     cnt_q, cnt_d;
    logic [memory_addr_width-1:0]   base_q, base_d;
    logic [memory_data_width-1:0]   head_q, head_d;
    logic [memory_data_width-1:0]   tail_q, tail_d;
    logic                           err_q, err_d;
    logic                           wait_go;
    logic                           wait_to;

    assign req_ready = power && mem_ready && (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_error = err_q;
    assign rsp_addr  = base_q;
    assign rsp_head  = head_q;
    assign rsp_tail  = tail_q;

    // The first wait cycle ignores mem_ready: memory_unit only drops it on
    // the edge that samples our execute strobe.
    assign wait_go = (cnt_q != 8'd0) && mem_ready;
    assign wait_to = (cnt_q == TIMEOUT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        head_d  = head_q;
        tail_d  = tail_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    base_d = req_addr;
                    head_d = req_head;
                    tail_d = req_tail;
                    err_d  = 1'b0;
                    if (req_op == OP_CONS) begin
                        state_d = ALLOC_REQ;
                    end else if (req_op == OP_READ && req_addr != ADDR_ONES) begin
                        state_d = RDH_REQ;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            ALLOC_REQ: begin
                state_d = ALLOC_WAIT;
                cnt_d   = 8'd0;
            end
            ALLOC_WAIT: begin
                if (wait_go) begin
                    base_d = mem_free_addr;
                    if (mem_free_addr == ADDR_ONES) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WRH_REQ;
                    end
                end else if (wait_to) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WRH_REQ: begin
                state_d = WRH_WAIT;
                cnt_d   = 8'd0;
            end
            WRH_WAIT: begin
                if (wait_go) begin
                    state_d = WRT_REQ;
                end else if (wait_to) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WRT_REQ: begin
                state_d = WRT_WAIT;
                cnt_d   = 8'd0;
            end
            WRT_WAIT: begin
                if (wait_go) begin
                    state_d = DONE;
                end else if (wait_to) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RDH_REQ: begin
                state_d = RDH_WAIT;
                cnt_d   = 8'd0;
            end
            RDH_WAIT: begin
                if (wait_go) begin
                    head_d  = mem_read_data;
                    state_d = RDT_REQ;
                end else if (wait_to) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RDT_REQ: begin
                state_d = RDT_WAIT;
                cnt_d   = 8'd0;
            end
            RDT_WAIT: begin
                if (wait_go) begin
                    tail_d  = mem_read_data;
                    state_d = DONE;
                end else if (wait_to) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command outputs are loaded from the next state so that mem_execute is a
    // flop that is high exactly during the REQ cycle; address/func/data only
    // change on REQ entry and therefore hold until the next command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            base_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            err_q          <= 1'b0;
            mem_execute    <= 1'b0;
            mem_func       <= 2'd0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else if (power) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            err_q       <= err_d;
            mem_execute <= 1'b0;
            case (state_d)
                ALLOC_REQ: begin
                    mem_execute    <= 1'b1;
                    mem_func       <= GET_FREE;
                    mem_write_data <= memory_data_width'(2);
                end
                WRH_REQ: begin
                    mem_execute    <= 1'b1;
                    mem_func       <= SET_CONTENTS;
                    mem_address    <= base_d;
                    mem_write_data <= head_d;
                end
                WRT_REQ: begin
                    mem_execute    <= 1'b1;
                    mem_func       <= SET_CONTENTS;
                    mem_address    <= base_d + memory_addr_width'(1);
                    mem_write_data <= tail_d;
                end
                RDH_REQ: begin
                    mem_execute    <= 1'b1;
                    mem_func       <= GET_CONTENTS;
                    mem_address    <= base_d;
                    mem_write_data <= '0;
                end
                RDT_REQ: begin
                    mem_execute    <= 1'b1;
                    mem_func       <= GET_CONTENTS;
                    mem_address    <= base_d + memory_addr_width'(1);
                    mem_write_data <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cell_unit.sv
// Testbench for cell_unit with a small behavioural memory_unit model.
module tb_cell_unit;

    localparam logic [1:0] GET_CONTENTS = 2'd0;
    localparam logic [1:0] SET_CONTENTS = 2'd1;
    localparam logic [1:0] GET_FREE     = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        power = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [9:0]  req_addr = '0;
    logic [63:0] req_head = '0;
    logic [63:0] req_tail = '0;
    logic        rsp_valid, rsp_error;
    logic [9:0]  rsp_addr;
    logic [63:0] rsp_head, rsp_tail;
    logic [1:0]  mem_func;
    logic        mem_execute;
    logic [9:0]  mem_address;
    logic [63:0] mem_write_data;
    logic        mem_ready;
    logic [9:0]  mem_free_addr;
    logic [63:0] mem_read_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cell_unit dut (
        .clk(clk), .rst(rst), .power(power),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_head(req_head), .req_tail(req_tail),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_addr(rsp_addr),
        .rsp_head(rsp_head), .rsp_tail(rsp_tail),
        .mem_func(mem_func), .mem_execute(mem_execute), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_ready(mem_ready),
        .mem_free_addr(mem_free_addr), .mem_read_data(mem_read_data)
    );

    // memory_unit model: GET_FREE answers after one busy cycle, reads and
    // writes after two; an allocation past the end never returns ready.
    logic [63:0] mem [0:1023];
    int          ptr_init = 32'h010;
    int          m_free_ptr;
    int          m_lat;
    logic        m_oom;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_ready     <= 1'b0;
            m_lat         <= 4;
            m_oom         <= 1'b0;
            m_free_ptr    <= ptr_init;
            mem_free_addr <= '0;
            mem_read_data <= '0;
        end else if (power) begin
            if (mem_execute) begin
                mem_ready <= 1'b0;
                case (mem_func)
                    GET_FREE: begin
                        m_lat <= 0;
                        if (m_free_ptr + int'(mem_write_data[3:0]) > 1024) begin
                            m_oom <= 1'b1;
                        end else begin
                            mem_free_addr <= 10'(m_free_ptr);
                            m_free_ptr    <= m_free_ptr + int'(mem_write_data[3:0]);
                        end
                    end
                    SET_CONTENTS: begin
                        m_lat <= 1;
                        mem[mem_address] <= mem_write_data;
                    end
                    default: begin
                        m_lat <= 1;
                        mem_read_data <= mem[mem_address];
                    end
                endcase
            end else if (!mem_ready && !m_oom) begin
                if (m_lat == 0) mem_ready <= 1'b1;
                else            m_lat <= m_lat - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          r_cycle;
    logic        r_err;
    logic [9:0]  r_addr;
    logic [63:0] r_head, r_tail;
    int          n_exec;
    int          exec_cyc [0:7];

    // Issues one request; cycle 0 is the accept edge, cycle k is sampled on
    // the negedge following the k-th edge after it.
    task automatic run_op(input logic [1:0] op, input logic [9:0] addr,
                          input logic [63:0] head, input logic [63:0] tail,
                          input int pause_at, input int pause_len,
                          input logic [9:0] pause_addr, input logic [63:0] pause_data);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_head  = head;
        req_tail  = tail;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        n_exec    = 0;
        r_cycle   = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (mem_execute && n_exec < 8) begin
                exec_cyc[n_exec] = k;
                n_exec++;
            end
            if (rsp_valid) begin
                r_cycle = k;
                r_err   = rsp_error;
                r_addr  = rsp_addr;
                r_head  = rsp_head;
                r_tail  = rsp_tail;
                break;
            end
            if (pause_len > 0 && k == pause_at) power = 1'b0;
            if (pause_len > 0 && k == pause_at + pause_len) begin
                chk("pause_exec", {63'd0, mem_execute}, 64'd0);
                chk("pause_func", {62'd0, mem_func}, {62'd0, SET_CONTENTS});
                chk("pause_addr", {54'd0, mem_address}, {54'd0, pause_addr});
                chk("pause_wdata", mem_write_data, pause_data);
                chk("pause_rsp", {63'd0, rsp_valid}, 64'd0);
                power = 1'b1;
            end
        end
        if (r_cycle < 0) chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int w;
        int seen;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_mem_exec", {63'd0, mem_execute}, 64'd0);
        chk("rst_rsp_addr", {54'd0, rsp_addr}, 64'd0);
        rst = 1'b1;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("init_ready", {63'd0, req_ready}, 64'd1);

        // CONS
        run_op(2'd1, 10'h000, 64'h2A, 64'h15, 0, 0, 10'h0, 64'h0);
        chk("cons_cycle", 64'(r_cycle), 64'd12);
        chk("cons_err", {63'd0, r_err}, 64'd0);
        chk("cons_addr", {54'd0, r_addr}, 64'h010);
        chk("cons_nexec", 64'(n_exec), 64'd3);
        chk("cons_exec0", 64'(exec_cyc[0]), 64'd1);
        chk("cons_exec1", 64'(exec_cyc[1]), 64'd4);
        chk("cons_exec2", 64'(exec_cyc[2]), 64'd8);
        chk("cons_mem_head", mem[10'h010], 64'h2A);
        chk("cons_mem_tail", mem[10'h011], 64'h15);

        // READ_CELL round trip
        run_op(2'd2, 10'h010, 64'h0, 64'h0, 0, 0, 10'h0, 64'h0);
        chk("read_cycle", 64'(r_cycle), 64'd9);
        chk("read_err", {63'd0, r_err}, 64'd0);
        chk("read_addr", {54'd0, r_addr}, 64'h010);
        chk("read_head", r_head, 64'h2A);
        chk("read_tail", r_tail, 64'h15);
        chk("read_nexec", 64'(n_exec), 64'd2);
        chk("read_exec0", 64'(exec_cyc[0]), 64'd1);
        chk("read_exec1", 64'(exec_cyc[1]), 64'd5);

        // second CONS
        run_op(2'd1, 10'h000, 64'h33, 64'h44, 0, 0, 10'h0, 64'h0);
        chk("cons2_addr", {54'd0, r_addr}, 64'h012);
        chk("cons2_head", r_head, 64'h33);
        chk("cons2_tail", r_tail, 64'h44);
        chk("cons2_mem_tail", mem[10'h013], 64'h44);

        // bad requests
        run_op(2'd0, 10'h005, 64'h0, 64'h0, 0, 0, 10'h0, 64'h0);
        chk("op0_cycle", 64'(r_cycle), 64'd1);
        chk("op0_err", {63'd0, r_err}, 64'd1);
        chk("op0_nexec", 64'(n_exec), 64'd0);
        run_op(2'd3, 10'h005, 64'h0, 64'h0, 0, 0, 10'h0, 64'h0);
        chk("op3_cycle", 64'(r_cycle), 64'd1);
        chk("op3_err", {63'd0, r_err}, 64'd1);
        chk("op3_nexec", 64'(n_exec), 64'd0);
        run_op(2'd2, 10'h3FF, 64'h0, 64'h0, 0, 0, 10'h0, 64'h0);
        chk("rd1s_cycle", 64'(r_cycle), 64'd1);
        chk("rd1s_err", {63'd0, r_err}, 64'd1);
        chk("rd1s_nexec", 64'(n_exec), 64'd0);

        // power gating for 20 cycles in WRH_WAIT
        run_op(2'd1, 10'h000, 64'h55, 64'h66, 5, 20, 10'h014, 64'h55);
        chk("pwr_cycle", 64'(r_cycle), 64'd32);
        chk("pwr_err", {63'd0, r_err}, 64'd0);
        chk("pwr_addr", {54'd0, r_addr}, 64'h014);
        chk("pwr_exec2", 64'(exec_cyc[2]), 64'd28);
        chk("pwr_mem_head", mem[10'h014], 64'h55);
        chk("pwr_mem_tail", mem[10'h015], 64'h66);

        // reset mid-CONS, while the head write strobe is high
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_head  = 64'h99;
        req_tail  = 64'hAA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        repeat (4) @(negedge clk);
        chk("mid_exec_pre", {63'd0, mem_execute}, 64'd1);
        ptr_init = 32'h3FF;
        rst = 1'b0;
        #1;
        chk("mid_exec", {63'd0, mem_execute}, 64'd0);
        chk("mid_req_ready", {63'd0, req_ready}, 64'd0);
        chk("mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("mid_mem_addr", {54'd0, mem_address}, 64'd0);
        chk("mid_wdata", mem_write_data, 64'd0);
        chk("mid_func", {62'd0, mem_func}, 64'd0);
        chk("mid_rsp_head", rsp_head, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            if (rsp_valid) seen++;
            w++;
        end
        chk("mid_ready_after", {63'd0, req_ready}, 64'd1);
        chk("mid_no_rsp", 64'(seen), 64'd0);

        // out of memory: allocation never completes
        run_op(2'd1, 10'h000, 64'h77, 64'h88, 0, 0, 10'h0, 64'h0);
        chk("oom_cycle", 64'(r_cycle), 64'd258);
        chk("oom_err", {63'd0, r_err}, 64'd1);
        chk("oom_nexec", 64'(n_exec), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
